// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared types for the decode stage. Holds the ALU control
//               encoding, the instruction width, the boolean constants, the
//               opcode/funct constants and the decoded control bundle.
// Revision    : 1.0  initial release
// ============================================================================
package decode_stage_pkg;

  localparam int INSN_W = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // ALU operation selector; MUL is only produced when the M extension is built in
  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_MUL = 3'd4
  } ctrALU;

  // Major opcodes
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  // funct3 selectors
  localparam logic [2:0] c_f3_word    = 3'b010;
  localparam logic [2:0] c_f3_add_sub = 3'b000;
  localparam logic [2:0] c_f3_and     = 3'b111;
  localparam logic [2:0] c_f3_or      = 3'b110;
  localparam logic [2:0] c_f3_beq     = 3'b000;
  localparam logic [2:0] c_f3_mul     = 3'b000;

  // funct7 selectors
  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;
  localparam logic [6:0] c_f7_mext = 7'b0000001;

  // Decoded control fields carried through the output buffer
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    ctrALU      alu;
    logic       rwe;
    logic       dwe;
    logic       dre;
    logic       br;
    logic       ill;
  } dec_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_insn_decode.sv
`default_nettype none
// ============================================================================
// Module      : insn_decode
// Description : Pure combinational instruction decoder. Recognises lw, sw,
//               add, sub, and, or, addi, beq (and mul when RV_M_EXT_EN is
//               defined); anything else is flagged illegal with all enables
//               low, ALU AND and zeroed fields.
// Config      : RV_M_EXT_EN - adds mul decode
// Revision    : 1.0  initial release
// ============================================================================
module insn_decode
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSN_W-1:0] insn_i,
  output dec_ctrl_t         ctrl_o,
  output logic [XLEN-1:0]   imm_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i_type;
  logic [XLEN-1:0] imm_s_type;
  logic [XLEN-1:0] imm_b_type;

  assign opcode = insn_i[6:0];
  assign funct3 = insn_i[14:12];
  assign funct7 = insn_i[31:25];

  assign imm_i_type = {{(XLEN-12){insn_i[31]}}, insn_i[31:20]};
  assign imm_s_type = {{(XLEN-12){insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
  assign imm_b_type = {{(XLEN-13){insn_i[31]}}, insn_i[31], insn_i[7],
                       insn_i[30:25], insn_i[11:8], 1'b0};

  // Classify the instruction and build its control bundle and immediate
  always_comb begin
    ctrl_o     = '0;
    ctrl_o.alu = ALU_AND;
    ctrl_o.ill = TRUE;
    imm_o      = '0;
    case (opcode)
      c_opc_load: begin
        if (funct3 == c_f3_word) begin
          ctrl_o.ill = FALSE;
          ctrl_o.rwe = TRUE;
          ctrl_o.dre = TRUE;
          ctrl_o.alu = ALU_ADD;
          imm_o      = imm_i_type;
        end
      end
      c_opc_store: begin
        if (funct3 == c_f3_word) begin
          ctrl_o.ill = FALSE;
          ctrl_o.dwe = TRUE;
          ctrl_o.alu = ALU_ADD;
          imm_o      = imm_s_type;
        end
      end
      c_opc_op_imm: begin
        if (funct3 == c_f3_add_sub) begin
          ctrl_o.ill = FALSE;
          ctrl_o.rwe = TRUE;
          ctrl_o.alu = ALU_ADD;
          imm_o      = imm_i_type;
        end
      end
      c_opc_branch: begin
        if (funct3 == c_f3_beq) begin
          ctrl_o.ill = FALSE;
          ctrl_o.br  = TRUE;
          ctrl_o.alu = ALU_SUB;
          imm_o      = imm_b_type;
        end
      end
      c_opc_op: begin
        // R-type carries no immediate, so imm_o stays zero
        case ({funct7, funct3})
          {c_f7_base, c_f3_add_sub}: begin
            ctrl_o.ill = FALSE;
            ctrl_o.rwe = TRUE;
            ctrl_o.alu = ALU_ADD;
          end
          {c_f7_alt, c_f3_add_sub}: begin
            ctrl_o.ill = FALSE;
            ctrl_o.rwe = TRUE;
            ctrl_o.alu = ALU_SUB;
          end
          {c_f7_base, c_f3_and}: begin
            ctrl_o.ill = FALSE;
            ctrl_o.rwe = TRUE;
            ctrl_o.alu = ALU_AND;
          end
          {c_f7_base, c_f3_or}: begin
            ctrl_o.ill = FALSE;
            ctrl_o.rwe = TRUE;
            ctrl_o.alu = ALU_OR;
          end
`ifdef RV_M_EXT_EN
          {c_f7_mext, c_f3_mul}: begin
            ctrl_o.ill = FALSE;
            ctrl_o.rwe = TRUE;
            ctrl_o.alu = ALU_MUL;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    // Register indices are only meaningful for recognised instructions
    if (!ctrl_o.ill) begin
      ctrl_o.rs1 = insn_i[19:15];
      ctrl_o.rs2 = insn_i[24:20];
      ctrl_o.rd  = insn_i[11:7];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode stage with a DEPTH-entry output FIFO.
//               Instructions are decoded on entry, buffered in order and
//               presented at the head with valid/ready handshakes. Counts
//               accepted illegal instructions (saturating) and supports a
//               flush that empties the buffer.
// Config      : RV_M_EXT_EN - decode mul (handled inside insn_decode)
// Revision    : 1.0  initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output ctrALU             out_aluCtr,
  output logic              out_registerWriteEnable,
  output logic              out_dataWriteEnable,
  output logic              out_dataReadEnable,
  output logic              out_branchCtr,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] c_depth = OCC_W'(DEPTH);

  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  dec_ctrl_t       ctrl_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] imm_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic      push;
  logic      pop;
  dec_ctrl_t head_ctrl;

  insn_decode #(
    .XLEN (XLEN)
  ) u_insn_decode (
    .insn_i (in_insn),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm)
  );

  assign in_ready      = in_ready_q;
  assign out_valid     = (occ_q != '0);
  assign push          = in_valid & in_ready_q;
  assign pop           = out_valid & out_ready;
  assign illegal_count = ill_cnt_q;

  // Next pointer/occupancy/counter state; flush wins over push and pop
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      if (push && dec_ctrl.ill && (ill_cnt_q != '1)) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
    end
    // Registered ready looks only at next occupancy, never at out_ready
    in_ready_d = (occ_d < c_depth);
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  // Buffer payload; contents are qualified by occupancy so need no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      ctrl_mem_q[wr_ptr_q] <= dec_ctrl;
      pc_mem_q[wr_ptr_q]   <= in_pc;
      imm_mem_q[wr_ptr_q]  <= dec_imm;
    end
  end

  // Present the head entry, forcing idle values when the buffer is empty
  always_comb begin
    head_ctrl               = ctrl_mem_q[rd_ptr_q];
    out_pc                  = '0;
    out_rs1                 = '0;
    out_rs2                 = '0;
    out_rd                  = '0;
    out_imm                 = '0;
    out_aluCtr              = ALU_AND;
    out_registerWriteEnable = 1'b0;
    out_dataWriteEnable     = 1'b0;
    out_dataReadEnable      = 1'b0;
    out_branchCtr           = 1'b0;
    out_illegal             = 1'b0;
    if (out_valid) begin
      out_pc                  = pc_mem_q[rd_ptr_q];
      out_imm                 = imm_mem_q[rd_ptr_q];
      out_rs1                 = head_ctrl.rs1;
      out_rs2                 = head_ctrl.rs2;
      out_rd                  = head_ctrl.rd;
      out_aluCtr              = head_ctrl.alu;
      out_registerWriteEnable = head_ctrl.rwe;
      out_dataWriteEnable     = head_ctrl.dwe;
      out_dataReadEnable      = head_ctrl.dre;
      out_branchCtr           = head_ctrl.br;
      out_illegal             = head_ctrl.ill;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. A queue-based reference
//               model with a table-driven decoder predicts every output.
//               A second instance with CNT_W=2 shares the stimulus to exercise
//               counter saturation.
// Config      : RV_M_EXT_EN - changes the expected mul decode
// Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  ctrALU       out_aluCtr;
  logic        out_rwe, out_dwe, out_dre, out_br, out_illegal;
  logic [15:0] illegal_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_imm;
  logic [4:0]  s_out_rs1, s_out_rs2, s_out_rd;
  ctrALU       s_out_aluCtr;
  logic        s_rwe, s_dwe, s_dre, s_br, s_illegal;
  logic [1:0]  s_illegal_count;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_aluCtr(out_aluCtr),
    .out_registerWriteEnable(out_rwe), .out_dataWriteEnable(out_dwe),
    .out_dataReadEnable(out_dre), .out_branchCtr(out_br),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2),
    .out_rd(s_out_rd), .out_imm(s_out_imm), .out_aluCtr(s_out_aluCtr),
    .out_registerWriteEnable(s_rwe), .out_dataWriteEnable(s_dwe),
    .out_dataReadEnable(s_dre), .out_branchCtr(s_br),
    .out_illegal(s_illegal), .illegal_count(s_illegal_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    ctrALU       alu;
    logic        rwe, dwe, dre, br, ill;
  } exp_t;

  entry_t mq[$];
  logic   m_ready;
  int     cnt_main;
  int     cnt_sat;
  int     errors = 0;
  int     checks = 0;

  // Instruction patterns: 0 lw, 1 sw, 2 add, 3 sub, 4 and, 5 or, 6 addi, 7 beq, 8 mul
  logic [31:0] pat_match [9] = '{32'h00002003, 32'h00002023, 32'h00000033,
                                 32'h40000033, 32'h00007033, 32'h00006033,
                                 32'h00000013, 32'h00000063, 32'h02000033};
  logic [31:0] pat_mask  [9] = '{32'h0000707F, 32'h0000707F, 32'hFE00707F,
                                 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                 32'h0000707F, 32'h0000707F, 32'hFE00707F};
`ifdef RV_M_EXT_EN
  localparam int NPAT = 9;
`else
  localparam int NPAT = 8;
`endif

  function automatic exp_t ref_decode(logic [31:0] w);
    exp_t e;
    int   kind = -1;
    int   s    = $signed(w);
    for (int i = 0; i < NPAT; i++)
      if ((w & pat_mask[i]) == pat_match[i]) kind = i;
    e.imm = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.alu = ALU_AND;
    e.rwe = 0; e.dwe = 0; e.dre = 0; e.br = 0; e.ill = 1;
    if (kind >= 0) begin
      e.ill = 0;
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.rd  = w[11:7];
    end
    case (kind)
      0: begin e.rwe = 1; e.dre = 1; e.alu = ALU_ADD; e.imm = 32'(s >>> 20); end
      1: begin e.dwe = 1; e.alu = ALU_ADD; e.imm = 32'(((s >>> 25) * 32) + int'(w[11:7])); end
      2: begin e.rwe = 1; e.alu = ALU_ADD; end
      3: begin e.rwe = 1; e.alu = ALU_SUB; end
      4: begin e.rwe = 1; e.alu = ALU_AND; end
      5: begin e.rwe = 1; e.alu = ALU_OR;  end
      6: begin e.rwe = 1; e.alu = ALU_ADD; e.imm = 32'(s >>> 20); end
      7: begin
        e.br = 1; e.alu = ALU_SUB;
        e.imm = 32'(((s >>> 31) * 4096) + int'(w[7]) * 2048 +
                    int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      end
      8: begin e.rwe = 1; e.alu = ALU_MUL; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: decide transfers from pre-edge inputs, then advance the model
  task automatic tick();
    bit   do_push, do_pop;
    exp_t e;
    do_push = in_valid && m_ready;
    do_pop  = (mq.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{insn: in_insn, pc: in_pc});
        e = ref_decode(in_insn);
        if (e.ill) begin
          if (cnt_main < 65535) cnt_main++;
          if (cnt_sat < 3) cnt_sat++;
        end
      end
    end
    m_ready = (mq.size() < DEPTH);
  endtask

  task automatic check_all(string ctx);
    exp_t        e;
    logic [31:0] pc;
    chk({ctx, ".valid"},   out_valid, mq.size() != 0);
    chk({ctx, ".ready"},   in_ready, m_ready);
    chk({ctx, ".cnt"},     illegal_count, cnt_main);
    chk({ctx, ".cnt_sat"}, s_illegal_count, cnt_sat);
    if (mq.size() != 0) begin
      e  = ref_decode(mq[0].insn);
      pc = mq[0].pc;
    end else begin
      e.imm = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.alu = ALU_AND;
      e.rwe = 0; e.dwe = 0; e.dre = 0; e.br = 0; e.ill = 0;
      pc = 0;
    end
    chk({ctx, ".pc"},  out_pc, pc);
    chk({ctx, ".rs1"}, out_rs1, e.rs1);
    chk({ctx, ".rs2"}, out_rs2, e.rs2);
    chk({ctx, ".rd"},  out_rd, e.rd);
    chk({ctx, ".imm"}, out_imm, e.imm);
    chk({ctx, ".alu"}, out_aluCtr, e.alu);
    chk({ctx, ".rwe"}, out_rwe, e.rwe);
    chk({ctx, ".dwe"}, out_dwe, e.dwe);
    chk({ctx, ".dre"}, out_dre, e.dre);
    chk({ctx, ".br"},  out_br, e.br);
    chk({ctx, ".ill"}, out_illegal, e.ill);
  endtask

  function automatic logic [31:0] rand_insn();
    int          k = $urandom_range(0, 11);
    logic [31:0] r = $urandom;
    if (k >= 9) return r;
    if (pat_mask[k] == 32'hFE00707F) return pat_match[k] | (r & 32'h01FF8F80);
    return pat_match[k] | (r & 32'hFFFF8F80);
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; in_insn = 0; in_pc = 0; flush = 0; out_ready = 0;
    m_ready = 0; cnt_main = 0; cnt_sat = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    // First edge after release raises in_ready
    rst_n = 1;
    tick();
    chk("ready_after_reset", in_ready, 1);
    check_all("post_reset");

    // add x3,x1,x2
    in_valid = 1; in_insn = 32'h002081B3; in_pc = 32'h0000_0100;
    tick();
    in_valid = 0;
    chk("add.valid", out_valid, 1);
    chk("add.rd", out_rd, 3);
    chk("add.rs1", out_rs1, 1);
    chk("add.rs2", out_rs2, 2);
    chk("add.alu", out_aluCtr, ALU_ADD);
    chk("add.rwe", out_rwe, 1);
    check_all("add");
    out_ready = 1;
    tick();
    check_all("add_drain");

    // lw x5,-4(x1)
    in_valid = 1; in_insn = 32'hFFC0A283; in_pc = 32'h0000_0104;
    tick();
    in_valid = 0;
    chk("lw.imm", out_imm, 32'hFFFFFFFC);
    chk("lw.dre", out_dre, 1);
    chk("lw.rd", out_rd, 5);
    check_all("lw");
    tick();

    // Backpressure: fill both entries, then drain in order
    out_ready = 0;
    in_valid = 1; in_insn = 32'h40208233; in_pc = 32'h0000_0200;
    tick();
    check_all("bp1");
    in_insn = 32'h0020F2B3; in_pc = 32'h0000_0204;
    tick();
    in_valid = 0;
    chk("bp.full_ready", in_ready, 0);
    check_all("bp2");
    repeat (2) begin
      tick();
      check_all("bp_hold");
    end
    chk("bp.head_pc_held", out_pc, 32'h0000_0200);
    out_ready = 1;
    tick();
    chk("bp.second_pc", out_pc, 32'h0000_0204);
    check_all("bp_drain1");
    tick();
    chk("bp.ready_back", in_ready, 1);
    check_all("bp_drain2");

    // Illegal words and counter saturation
    in_valid = 1; in_insn = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h300 + 32'(i * 4);
      tick();
      chk("ill.flag", out_illegal, 1);
      check_all("ill");
    end
    chk("ill.count3", illegal_count, 3);
    chk("ill.sat_count3", s_illegal_count, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("ill_more");
    end
    chk("ill.count6", illegal_count, 6);
    chk("ill.sat_hold", s_illegal_count, 3);
    in_valid = 0;
    tick();
    check_all("ill_drain");

    // Flush with full buffer and a pending push
    out_ready = 0; in_valid = 1; in_insn = 32'h00A00093;
    in_pc = 32'h400; tick();
    in_pc = 32'h404; tick();
    in_insn = 32'hFFFFFFFF; in_pc = 32'h408; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_full.valid", out_valid, 0);
    check_all("flush_full");
    // Flush with one entry, same-cycle push of an illegal word and pop
    in_valid = 1; in_insn = 32'h00A00093; in_pc = 32'h500; tick();
    in_insn = 32'hFFFFFFFF; in_pc = 32'h504; out_ready = 1; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_push.valid", out_valid, 0);
    chk("flush_push.cnt", illegal_count, 6);
    tick();
    chk("flush_push.never", out_valid, 0);
    check_all("flush_push");

    // mul x3,x1,x2
    in_valid = 1; in_insn = 32'h022081B3; in_pc = 32'h600;
    out_ready = 0;
    tick();
    in_valid = 0;
`ifdef RV_M_EXT_EN
    chk("mul.alu", out_aluCtr, ALU_MUL);
    chk("mul.ill", out_illegal, 0);
`else
    chk("mul.ill", out_illegal, 1);
    chk("mul.alu", out_aluCtr, ALU_AND);
`endif
    check_all("mul");
    out_ready = 1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_insn   = rand_insn();
      in_pc     = $urandom;
      tick();
      check_all("rand");
    end
    flush = 0;

    // Reset mid-stream clears everything immediately
    out_ready = 0; in_valid = 1; in_insn = 32'h002081B3; in_pc = 32'h700;
    tick(); tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    mq.delete(); m_ready = 0; cnt_main = 0; cnt_sat = 0;
    chk("midrst.valid", out_valid, 0);
    chk("midrst.ready", in_ready, 0);
    check_all("midrst");
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    chk("midrst.ready_back", in_ready, 1);
    check_all("midrst_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32; data/PC/immediate width.
REQ-002 SHALL have parameter DEPTH, default 2; output buffer entries, power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16; illegal-instruction counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an instruction.
REQ-009 SHALL have port in_insn, input, 32 bits: instruction word.
REQ-010 SHALL have port in_pc, input, XLEN bits: instruction address.
REQ-011 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-012 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-014 SHALL have port out_pc, output, XLEN bits: PC of the head entry.
REQ-015 SHALL have ports out_rs1, out_rs2 and out_rd, outputs, 5 bits each: register indices.
REQ-016 SHALL have port out_imm, output, XLEN bits: sign-extended immediate.
REQ-017 SHALL have port out_aluCtr, output, ctrALU: ALU operation.
REQ-018 SHALL have ports out_registerWriteEnable, out_dataWriteEnable, out_dataReadEnable and out_branchCtr, outputs, 1 bit each: control signals.
REQ-019 SHALL have port out_illegal, output, 1 bit: head entry is an unrecognised instruction.
REQ-020 SHALL have port illegal_count, output, CNT_W bits: saturating count of accepted illegal instructions.

Function
REQ-021 SHALL push when in_valid and in_ready; SHALL pop when out_valid and out_ready.
REQ-022 SHALL register in_ready as (occupancy < DEPTH), independent of out_ready in the same cycle; a full buffer with a pop SHALL raise in_ready the next cycle.
REQ-023 SHALL present an instruction pushed into an empty buffer in cycle N at the outputs with out_valid=1 in cycle N+1.
REQ-024 SHALL keep the head outputs stable while out_valid=1 and out_ready=0, and SHALL preserve FIFO order.
REQ-025 SHALL, on simultaneous push and pop, leave occupancy unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-026 SHALL decode lw, sw, add, sub, and, or, addi and beq by {funct7, funct3, opcode}: lw sets registerWriteEnable and dataReadEnable with aluCtr ADD; sw sets dataWriteEnable with ADD; add/sub/and/or set registerWriteEnable with the matching aluCtr; addi sets registerWriteEnable with ADD; beq sets branchCtr with SUB.
REQ-027 SHALL produce I-, S- and B-type immediates sign-extended to XLEN (B-type with LSB 0), and 0 for R-type.
REQ-028 SHALL decode any other encoding as illegal: out_illegal=1, all enables 0, aluCtr AND.
REQ-029 SHALL increment illegal_count when an illegal instruction is pushed, and SHALL saturate at all-ones.
REQ-030 SHALL, when flush=1, empty the buffer so that out_valid=0 the next cycle; flush SHALL override a same-cycle push or pop, and the flushed push SHALL NOT count toward illegal_count.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear occupancy and pointers, and set out_valid=0, in_ready=0 and illegal_count=0.
REQ-032 SHALL drive in_ready=1 on the first clock edge after reset deasserts.
REQ-033 SHALL drive the data outputs to 0 and out_aluCtr to AND while out_valid=0.
REQ-034 SHALL discard all in-flight entries on a reset asserted mid-operation.

Configuration
REQ-035 SHALL, when RV_M_EXT_EN is defined, decode mul (funct7 0000001, funct3 000, opcode 0110011) as registerWriteEnable with aluCtr MUL.
REQ-036 SHALL, when RV_M_EXT_EN is undefined, decode mul as illegal, and SHALL contain no MUL logic.

Structure
REQ-037 SHALL take ctrALU (extended with MUL), the instruction width macro and TRUE/FALSE from the shared Types.v; opcode constants SHALL be added there.
REQ-038 SHALL place the pure combinational decode in one sub-module, insn_decode, which decode_stage instantiates before the buffer.

Verification
REQ-039 SHALL verify: push 0x002081B3 (add x3,x1,x2) to an empty buffer -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, aluCtr ADD, registerWriteEnable=1.
REQ-040 SHALL verify: push 0xFFC0A283 (lw x5,-4(x1)) -> out_imm=0xFFFFFFFC, dataReadEnable=1, rd=5.
REQ-041 SHALL verify: out_ready=0 and push 2 instructions -> in_ready=0; raise out_ready -> both drain in order and in_ready returns to 1.
REQ-042 SHALL verify: push 0xFFFFFFFF three times -> out_illegal=1 each time and illegal_count=3; with CNT_W=2, six pushes -> count holds at 3.
REQ-043 SHALL verify: flush with a full buffer and a same-cycle push -> out_valid=0 next cycle, and the flushed instruction never appears.
REQ-044 SHALL verify: push 0x022081B3 -> aluCtr MUL with RV_M_EXT_EN defined; out_illegal=1 without it; reset asserted mid-stream -> out_valid=0 immediately.
